// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
//   Shared definitions for the ALU control sequencer family: sequencer state
//   encoding and the default ALU control codes / widths used as parameter
//   defaults by alu_ctrl_seq and alu_ctrl_sel.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package alu_ctrl_pkg;

  localparam int DEF_CTRL_W = 5;
  localparam int DEF_CNT_W  = 4;

  localparam logic [DEF_CTRL_W-1:0] DEF_IDLE_CODE = 5'h00;
  localparam logic [DEF_CTRL_W-1:0] DEF_INC_CODE  = 5'h01;
  localparam logic [DEF_CTRL_W-1:0] DEF_DEC_CODE  = 5'h11;
  localparam logic [DEF_CTRL_W-1:0] DEF_ADDR_CODE = 5'h02;

  // IDLE: waiting for an operation; ADDR: effective-address beat live;
  // MAIN: main-operation beat(s) live.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_MAIN = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ctrl_sel.sv
// ---------------------------------------------------------------------------
// alu_ctrl_sel
//   Combinational main-beat selector: priority mux from decoded mode flags to
//   the ALU control code of the main operation.
//     inc/dec  -> dec ? DEC_CODE : INC_CODE
//     else mov -> ctrl passed through
//     else     -> IDLE_CODE
// Ports:
//   ctrl     in  CTRL_W  raw control field
//   mov      in  1       pass ctrl through
//   inc_dec  in  1       internal increment/decrement (wins over mov)
//   dec      in  1       select decrement when inc_dec is set
//   code     out CTRL_W  selected main-beat code
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_ctrl_sel
  import alu_ctrl_pkg::*;
#(
  parameter int                 CTRL_W    = DEF_CTRL_W,
  parameter logic [CTRL_W-1:0]  IDLE_CODE = CTRL_W'(DEF_IDLE_CODE),
  parameter logic [CTRL_W-1:0]  INC_CODE  = CTRL_W'(DEF_INC_CODE),
  parameter logic [CTRL_W-1:0]  DEC_CODE  = CTRL_W'(DEF_DEC_CODE)
) (
  input  logic [CTRL_W-1:0] ctrl,
  input  logic              mov,
  input  logic              inc_dec,
  input  logic              dec,
  output logic [CTRL_W-1:0] code
);

  always_comb begin
    if (inc_dec) begin
      code = dec ? DEC_CODE : INC_CODE;
    end else if (mov) begin
      code = ctrl;
    end else begin
      code = IDLE_CODE;
    end
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//   Registered ALU control sequencer. Accepts one decoded operation under a
//   valid/ready handshake and issues ALU control beats: an optional
//   effective-address beat, then the main beat repeated REPEAT+1 times for
//   internal inc/dec (once otherwise). Each beat is held until ALU_READY.
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   OP_VALID/OP_READY   operation handshake (ready only in IDLE)
//   CTRL, INTERNAL_MOV, ADDRESS_MODE, INTERNAL_INC_DEC, INTERNAL_DEC, REPEAT
//                       operation fields, captured on the accept edge
//   ALU_READY           ALU consumes the current beat
//   CTRL_OUT            registered ALU control word
//   CTRL_VALID          CTRL_OUT is a live beat
//   ADDR_PHASE          current beat is the address beat
//   STEP_LAST           current beat is the final beat of the operation
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int                 CTRL_W    = DEF_CTRL_W,
  parameter int                 CNT_W     = DEF_CNT_W,
  parameter logic [CTRL_W-1:0]  IDLE_CODE = CTRL_W'(DEF_IDLE_CODE),
  parameter logic [CTRL_W-1:0]  INC_CODE  = CTRL_W'(DEF_INC_CODE),
  parameter logic [CTRL_W-1:0]  DEC_CODE  = CTRL_W'(DEF_DEC_CODE),
  parameter logic [CTRL_W-1:0]  ADDR_CODE = CTRL_W'(DEF_ADDR_CODE)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              OP_VALID,
  output logic              OP_READY,
  input  logic [CTRL_W-1:0] CTRL,
  input  logic              INTERNAL_MOV,
  input  logic              ADDRESS_MODE,
  input  logic              INTERNAL_INC_DEC,
  input  logic              INTERNAL_DEC,
  input  logic [CNT_W-1:0]  REPEAT,
  input  logic              ALU_READY,
  output logic [CTRL_W-1:0] CTRL_OUT,
  output logic              CTRL_VALID,
  output logic              ADDR_PHASE,
  output logic              STEP_LAST
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CTRL_W-1:0]   main_code_q, main_code_d;
  logic [CTRL_W-1:0]   ctrl_out_q, ctrl_out_d;
  logic [CTRL_W-1:0]   sel_code;

  // The main code is resolved from the live inputs at accept time and only
  // the resulting code is stored, rather than the raw fields and flags.
  alu_ctrl_sel #(
    .CTRL_W    (CTRL_W),
    .IDLE_CODE (IDLE_CODE),
    .INC_CODE  (INC_CODE),
    .DEC_CODE  (DEC_CODE)
  ) u_sel (
    .ctrl    (CTRL),
    .mov     (INTERNAL_MOV),
    .inc_dec (INTERNAL_INC_DEC),
    .dec     (INTERNAL_DEC),
    .code    (sel_code)
  );

  always_comb begin
    // NOTE: every always_comb output is defaulted (hold) before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    main_code_d = main_code_q;
    ctrl_out_d  = ctrl_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (OP_VALID) begin
          main_code_d = sel_code;
          // Counter holds remaining main beats minus one; REPEAT all-ones
          // yields 2^CNT_W beats without needing an extra counter bit.
          cnt_d       = INTERNAL_INC_DEC ? REPEAT : '0;
          if (ADDRESS_MODE) begin
            state_d    = ST_ADDR;
            ctrl_out_d = ADDR_CODE;
          end else begin
            state_d    = ST_MAIN;
            ctrl_out_d = sel_code;
          end
        end
      end

      ST_ADDR: begin
        if (ALU_READY) begin
          state_d    = ST_MAIN;
          ctrl_out_d = main_code_q;
        end
      end

      ST_MAIN: begin
        if (ALU_READY) begin
          if (cnt_q == '0) begin
            state_d    = ST_IDLE;
            ctrl_out_d = IDLE_CODE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        ctrl_out_d = IDLE_CODE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      main_code_q <= IDLE_CODE;
      ctrl_out_q  <= IDLE_CODE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      main_code_q <= main_code_d;
      ctrl_out_q  <= ctrl_out_d;
    end
  end

  // Status outputs are pure decodes of registered state, so they change only
  // on the clock edge (or asynchronously with reset) together with CTRL_OUT.
  assign OP_READY   = (state_q == ST_IDLE);
  assign CTRL_VALID = (state_q != ST_IDLE);
  assign ADDR_PHASE = (state_q == ST_ADDR);
  assign STEP_LAST  = (state_q == ST_MAIN) && (cnt_q == '0);
  assign CTRL_OUT   = ctrl_out_q;

endmodule
